// File: rtl/pattern_run_ctrl.sv
// Serial pattern detector with run control: counts matches of a configurable
// pattern in a qualified bit stream until a match limit, an abort or a reset.
module pattern_run_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             q,
    input  logic             q_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic [1:0]       status
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [PAT_W-1:0]  PAT_ONE  = PAT_W'(1);

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_LIMIT = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;
    localparam logic [1:0] ST_CFG   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [3:0]        len_q, len_d;
    logic              overlap_q, overlap_d;
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        status_q, status_d;
    logic              match_q, match_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [PAT_W-1:0]  histShift;
    logic [FILL_W-1:0] fillInc;
    logic [PAT_W-1:0]  lenMask;
    logic              fillOk;
    logic              patHit;
    logic              cfgBad;
    logic [CNT_W-1:0]  countInc;

    // Match is judged on the history as it will look once the incoming bit is in.
    always_comb begin
        histShift = {hist_q[PAT_W-2:0], q};
        fillInc   = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
        lenMask   = (PAT_ONE << len_q) - PAT_ONE;
        fillOk    = 32'(fillInc) >= 32'(len_q);
        patHit    = ((histShift ^ pattern_q) & lenMask) == '0;
        countInc  = count_q + CNT_W'(1);
        cfgBad    = (cfg_len == 4'd0) || (32'(cfg_len) > PAT_W) || (cfg_limit == '0);
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        limit_d   = limit_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        status_d  = status_q;
        match_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    overlap_d = cfg_overlap;
                    limit_d   = cfg_limit;
                    hist_d    = '0;
                    fill_d    = '0;
                    count_d   = '0;
                    if (cfgBad) begin
                        state_d  = DONE;
                        status_d = ST_CFG;
                    end else begin
                        state_d  = RUN;
                        status_d = ST_NONE;
                    end
                end
            end
            RUN: begin
                if (q_valid) begin
                    hist_d = histShift;
                    fill_d = fillInc;
                    if (fillOk && patHit) begin
                        match_d = 1'b1;
                        count_d = countInc;
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                    end
                end
                // A match that reaches the limit outranks a simultaneous abort.
                if (match_d && (countInc == limit_q)) begin
                    state_d  = DONE;
                    status_d = ST_LIMIT;
                end else if (abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            limit_q   <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            status_q  <= ST_NONE;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            limit_q   <= limit_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            status_q  <= status_d;
            match_q   <= match_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign match       = match_q;
    assign match_count = count_q;
    assign done        = done_q;
    assign status      = status_q;

endmodule
